// File: rtl/mem_arb_pkg.sv
// Shared types and encodings for the two-port memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } arb_state_t;

  localparam logic SIZE_BYTE  = 1'b0;
  localparam logic SIZE_WORD  = 1'b1;

  localparam logic PORT_FETCH = 1'b0;
  localparam logic PORT_DATA  = 1'b1;

endpackage

// File: rtl/mem_arb_grant.sv
// Grant picker for the two requesters.
// MEM_ARB_ROUND_ROBIN_EN selects round-robin; otherwise the data port has fixed priority.
module mem_arb_grant
  import mem_arb_pkg::*;
(
  input  logic       Clock,
  input  logic       Reset,
  input  logic [1:0] req,
  input  logic       take,
  output logic       any_req,
  output logic       grant_port
);

  assign any_req = |req;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic last_q;

  // Resetting to the data port lets fetch win the first tie.
  always_ff @(posedge Clock) begin
    if (Reset)               last_q <= PORT_DATA;
    else if (take && any_req) last_q <= grant_port;
  end

  always_comb begin
    grant_port = req[1];
    if (&req) grant_port = ~last_q;
  end
`else
  logic unused_rr;

  assign grant_port = req[1];
  assign unused_rr  = ^{Clock, Reset, take};
`endif

endmodule

// File: rtl/memory_arbiter.sv
// Shares the byte-wide memory between fetch (port 0) and data (port 1), splitting
// words into little-endian byte cycles. Arbitration mode: MEM_ARB_ROUND_ROBIN_EN.
module memory_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  P0_Req,
  input  logic [ADDR_WIDTH-1:0] P0_Addr,
  output logic                  P0_Ack,
  output logic [15:0]           P0_RData,
  input  logic                  P1_Req,
  input  logic                  P1_We,
  input  logic                  P1_Size,
  input  logic [ADDR_WIDTH-1:0] P1_Addr,
  input  logic [15:0]           P1_WData,
  output logic                  P1_Ack,
  output logic [15:0]           P1_RData,
  output logic [ADDR_WIDTH-1:0] Mem_Address,
  output logic [7:0]            Mem_Data,
  output logic                  Mem_WR,
  output logic                  Mem_CS,
  input  logic [7:0]            Mem_Out,
  output logic                  Busy
);

  arb_state_t            state_q, state_d;
  logic                  any_req, grant_port;
  logic                  txn_port, txn_we, txn_size;
  logic [ADDR_WIDTH-1:0] txn_addr;
  logic [15:0]           txn_wdata;
  logic [7:0]            lo_q;
  logic                  rd_ld;
  logic [15:0]           rd_val;

  mem_arb_grant u_grant (
    .Clock      (Clock),
    .Reset      (Reset),
    .req        ({P1_Req, P0_Req}),
    .take       (state_q == IDLE),
    .any_req    (any_req),
    .grant_port (grant_port)
  );

  // Read data lands in the port's RData on the edge that enters DONE.
  assign rd_ld  = !txn_we && ((state_q == LO && txn_size == SIZE_BYTE) || state_q == HI);
  assign rd_val = (state_q == HI) ? {Mem_Out, lo_q} : {8'h00, Mem_Out};

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q   <= IDLE;
      txn_port  <= PORT_FETCH;
      txn_we    <= 1'b0;
      txn_size  <= SIZE_BYTE;
      txn_addr  <= '0;
      txn_wdata <= '0;
      lo_q      <= '0;
      P0_RData  <= '0;
      P1_RData  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && any_req) begin
        txn_port  <= grant_port;
        txn_we    <= (grant_port == PORT_DATA) && P1_We;
        txn_size  <= (grant_port == PORT_DATA) ? P1_Size : SIZE_WORD;
        txn_addr  <= (grant_port == PORT_DATA) ? P1_Addr : P0_Addr;
        txn_wdata <= (grant_port == PORT_DATA) ? P1_WData : 16'h0000;
      end
      if (state_q == LO && !txn_we) lo_q <= Mem_Out;
      if (rd_ld) begin
        if (txn_port == PORT_DATA) P1_RData <= rd_val;
        else                       P0_RData <= rd_val;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    Mem_CS      = 1'b1;
    Mem_WR      = 1'b0;
    Mem_Address = '0;
    Mem_Data    = '0;
    case (state_q)
      IDLE: if (any_req) state_d = LO;
      LO: begin
        Mem_CS      = 1'b0;
        Mem_WR      = txn_we;
        Mem_Address = txn_addr;
        Mem_Data    = txn_wdata[7:0];
        state_d     = (txn_size == SIZE_WORD) ? HI : DONE;
      end
      HI: begin
        Mem_CS      = 1'b0;
        Mem_WR      = txn_we;
        Mem_Address = txn_addr + ADDR_WIDTH'(1);
        Mem_Data    = txn_wdata[15:8];
        state_d     = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // A reset landing mid-word must not let the pending byte cycle write.
    if (Reset) begin
      Mem_CS = 1'b1;
      Mem_WR = 1'b0;
    end
  end

  assign Busy   = (state_q != IDLE);
  assign P0_Ack = (state_q == DONE) && (txn_port == PORT_FETCH);
  assign P1_Ack = (state_q == DONE) && (txn_port == PORT_DATA);

endmodule

// File: tb/tb_memory_arbiter.sv
// Scoreboard bench for memory_arbiter with a behavioural byte-wide memory.
// Expected arbitration order follows MEM_ARB_ROUND_ROBIN_EN.
module tb_memory_arbiter;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        P0_Req = 1'b0;
  logic [15:0] P0_Addr = '0;
  logic        P0_Ack;
  logic [15:0] P0_RData;
  logic        P1_Req = 1'b0, P1_We = 1'b0, P1_Size = 1'b0;
  logic [15:0] P1_Addr = '0, P1_WData = '0;
  logic        P1_Ack;
  logic [15:0] P1_RData;
  logic [15:0] Mem_Address;
  logic [7:0]  Mem_Data;
  logic        Mem_WR, Mem_CS;
  logic [7:0]  Mem_Out;
  logic        Busy;

  logic [7:0]  mem [0:65535];
  logic        ld_en = 1'b0;
  logic [15:0] ld_addr = '0;
  logic [7:0]  ld_data = '0;

  typedef struct {
    logic        port;
    logic [15:0] rdata;
    logic        chk_data;
  } exp_t;
  exp_t exp_q [$];

  int errors = 0;
  int checks = 0;

  memory_arbiter #(.ADDR_WIDTH(16)) dut (
    .Clock(Clock), .Reset(Reset),
    .P0_Req(P0_Req), .P0_Addr(P0_Addr), .P0_Ack(P0_Ack), .P0_RData(P0_RData),
    .P1_Req(P1_Req), .P1_We(P1_We), .P1_Size(P1_Size), .P1_Addr(P1_Addr),
    .P1_WData(P1_WData), .P1_Ack(P1_Ack), .P1_RData(P1_RData),
    .Mem_Address(Mem_Address), .Mem_Data(Mem_Data), .Mem_WR(Mem_WR),
    .Mem_CS(Mem_CS), .Mem_Out(Mem_Out), .Busy(Busy)
  );

  always #5 Clock = ~Clock;

  assign Mem_Out = mem[Mem_Address];

  always @(posedge Clock) begin
    if (ld_en)                mem[ld_addr]     <= ld_data;
    else if (!Mem_CS && Mem_WR) mem[Mem_Address] <= Mem_Data;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic port, input logic [15:0] rdata, input logic chk_data);
    exp_t e;
    e.port = port; e.rdata = rdata; e.chk_data = chk_data;
    exp_q.push_back(e);
  endtask

  task automatic poke(input logic [15:0] a, input logic [7:0] d);
    ld_addr = a; ld_data = d; ld_en = 1'b1;
    @(posedge Clock); #1;
    ld_en = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 10 && Busy; i++) begin
      @(posedge Clock); #1;
    end
    chk("wait_idle", Busy, 1'b0);
  endtask

  task automatic issue(input logic port, input logic we, input logic size,
                       input logic [15:0] addr, input logic [15:0] wdata,
                       input logic [15:0] exp_rd, input int lat, input string name);
    int n;
    wait_idle();
    push(port, exp_rd, !we);
    if (port) begin
      P1_Req = 1'b1; P1_We = we; P1_Size = size; P1_Addr = addr; P1_WData = wdata;
    end else begin
      P0_Req = 1'b1; P0_Addr = addr;
    end
    n = 0;
    do begin
      @(posedge Clock); #1; n++;
    end while (!(port ? P1_Ack : P0_Ack) && n < 20);
    chk({name, "_latency"}, n, lat);
    P0_Req = 1'b0; P1_Req = 1'b0;
  endtask

  // Monitor: every acknowledge is matched against the oldest expectation.
  always @(negedge Clock) begin
    exp_t e;
    if (P0_Ack || P1_Ack) begin
      chk("single_ack", P0_Ack && P1_Ack, 1'b0);
      chk("cs_high_on_ack", Mem_CS, 1'b1);
      if (exp_q.size() == 0) begin
        chk("unexpected_ack", 1'b1, 1'b0);
      end else begin
        e = exp_q.pop_front();
        chk("ack_port", P1_Ack, e.port);
        if (e.chk_data) chk("rdata", e.port ? P1_RData : P0_RData, e.rdata);
      end
    end
    if (!Mem_CS) chk("cs_only_when_busy", Busy, 1'b1);
    if (Mem_WR)  chk("wr_needs_cs", Mem_CS, 1'b0);
  end

  initial begin
    int n, acks;
    for (int i = 0; i < 3; i++) @(posedge Clock);
    #1;
    chk("rst_cs", Mem_CS, 1'b1);
    chk("rst_wr", Mem_WR, 1'b0);
    chk("rst_addr", Mem_Address, 16'h0000);
    chk("rst_data", Mem_Data, 8'h00);
    chk("rst_acks", {P0_Ack, P1_Ack}, 2'b00);
    chk("rst_p0_rdata", P0_RData, 16'h0000);
    chk("rst_p1_rdata", P1_RData, 16'h0000);
    chk("rst_busy", Busy, 1'b0);

    poke(16'h0010, 8'h34); poke(16'h0011, 8'h12);
    poke(16'hFFFF, 8'hCD); poke(16'h0000, 8'hAB);
    poke(16'h0301, 8'h99);
    poke(16'h0400, 8'h00); poke(16'h0401, 8'h77);
    Reset = 1'b0;
    @(posedge Clock); #1;

    issue(1'b0, 1'b0, 1'b1, 16'h0010, 16'h0000, 16'h1234, 3, "fetch");

    issue(1'b1, 1'b1, 1'b1, 16'h0200, 16'hBEEF, 16'h0000, 3, "wr_word");
    chk("mem_200", mem[16'h0200], 8'hEF);
    chk("mem_201", mem[16'h0201], 8'hBE);
    issue(1'b1, 1'b0, 1'b1, 16'h0200, 16'h0000, 16'hBEEF, 3, "rd_word");

    issue(1'b1, 1'b1, 1'b0, 16'h0300, 16'h775A, 16'h0000, 2, "wr_byte");
    chk("mem_300", mem[16'h0300], 8'h5A);
    chk("mem_301", mem[16'h0301], 8'h99);
    issue(1'b1, 1'b0, 1'b0, 16'h0300, 16'h0000, 16'h005A, 2, "rd_byte");

    issue(1'b1, 1'b0, 1'b1, 16'hFFFF, 16'h0000, 16'hABCD, 3, "rd_wrap");
    chk("p0_rdata_hold", P0_RData, 16'h1234);

    // Both ports hold requests for four back-to-back words.
    wait_idle();
`ifdef MEM_ARB_ROUND_ROBIN_EN
    push(1'b0, 16'h1234, 1'b1); push(1'b1, 16'hBEEF, 1'b1);
    push(1'b0, 16'h1234, 1'b1); push(1'b1, 16'hBEEF, 1'b1);
`else
    for (int i = 0; i < 4; i++) push(1'b1, 16'hBEEF, 1'b1);
`endif
    P0_Req = 1'b1; P0_Addr = 16'h0010;
    P1_Req = 1'b1; P1_We = 1'b0; P1_Size = 1'b1; P1_Addr = 16'h0200;
    n = 0; acks = 0;
    while (acks < 4 && n < 60) begin
      @(posedge Clock); #1; n++;
      if (P0_Ack || P1_Ack) acks++;
    end
    P0_Req = 1'b0; P1_Req = 1'b0;
    chk("contention_acks", acks, 4);
    chk("contention_cycles", n, 15);

    // Reset lands during HI of a word write.
    wait_idle();
    P1_Req = 1'b1; P1_We = 1'b1; P1_Size = 1'b1; P1_Addr = 16'h0400; P1_WData = 16'h1122;
    @(posedge Clock); #1;
    @(posedge Clock); #1;
    chk("mid_busy_hi", Busy, 1'b1);
    Reset = 1'b1; P1_Req = 1'b0;
    @(posedge Clock); #1;
    chk("mid_busy_after", Busy, 1'b0);
    chk("mid_no_ack", P1_Ack, 1'b0);
    chk("mid_mem_400", mem[16'h0400], 8'h22);
    chk("mid_mem_401", mem[16'h0401], 8'h77);
    Reset = 1'b0;
    @(posedge Clock); #1;

    issue(1'b0, 1'b0, 1'b1, 16'h0010, 16'h0000, 16'h1234, 3, "fetch_after_rst");
    @(posedge Clock); #1;
    chk("queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/memory_arbiter.md
# memory_arbiter

Two-port arbiter and access sequencer in front of the byte-wide 64 KiB `Memory` block. It shares the single memory port between an instruction-fetch requester (port 0, word reads only) and a data requester (port 1, byte/word reads and writes). It splits 16-bit accesses into two little-endian byte cycles and returns results with a one-cycle acknowledge.

## Interface
- `ADDR_WIDTH`, 16, memory address width; address arithmetic wraps modulo 2^ADDR_WIDTH.
- `Clock`  in  1  sole clock; all state updates on rising edge.
- `Reset`  in  1  synchronous, active-high reset.
- `P0_Req`  in  1  fetch request; held until `P0_Ack`.
- `P0_Addr`  in  16  fetch word address (low byte address).
- `P0_Ack`  out  1  one-cycle completion pulse.
- `P0_RData`  out  16  fetched word; valid when `P0_Ack`=1, held until next P0 ack.
- `P1_Req`  in  1  data request; held until `P1_Ack`.
- `P1_We`  in  1  1=write, 0=read.
- `P1_Size`  in  1  0=byte, 1=word.
- `P1_Addr`  in  16  data address.
- `P1_WData`  in  16  write data; byte writes use [7:0].
- `P1_Ack`  out  1  one-cycle completion pulse.
- `P1_RData`  out  16  read data; byte reads return {8'h00, byte}; valid when `P1_Ack`=1, held until next P1 ack.
- `Mem_Address`  out  16  to `Memory.Address`.
- `Mem_Data`  out  8  to `Memory.Data`.
- `Mem_WR`  out  1  to `Memory.WR` (1=write).
- `Mem_CS`  out  1  to `Memory.CS` (active-low).
- `Mem_Out`  in  8  from `Memory.MemOut`; combinational read data.
- `Busy`  out  1  high in every state except IDLE.

## Operation
- FSM states: IDLE, LO, HI, DONE.
- IDLE: if any `Px_Req` is high, grant one port. Latch port id, address, we, size and wdata, then go to LO. Otherwise stay.
- Request inputs are sampled only in IDLE. Changes after grant are ignored.
- LO: `Mem_Address`=A, `Mem_CS`=0, `Mem_WR`=we, `Mem_Data`=wdata[7:0].
  - Reads capture `Mem_Out` into the low byte at the edge ending LO.
  - Next state is HI for word accesses, DONE for byte accesses.
- HI: `Mem_Address`=A+1 (FFFF+1 wraps to 0000), `Mem_Data`=wdata[15:8]. Reads capture the high byte. Next state is DONE.
- DONE: pulse the granted port's `Ack` and drive the assembled `RData`. `Mem_CS`=1. Next state is IDLE.
- Outside LO/HI: `Mem_CS`=1, `Mem_WR`=0. Writes are never issued with CS deasserted.
- Arbitration when both ports request in the same IDLE cycle is set by the Configuration section.
- Fetch writes are impossible: P0 is always read.

## Timing
- Reset values:
  - state=IDLE
  - `Mem_CS`=1, `Mem_WR`=0, `Mem_Address`=0, `Mem_Data`=0
  - `P0_Ack`=`P1_Ack`=0, `P0_RData`=`P1_RData`=0
  - `Busy`=0
  - last-grant pointer = port 1, so port 0 wins the first tie.
- Word latency: Req seen in IDLE at cycle n → LO at n+1 → HI at n+2 → Ack at n+3.
- Byte latency: Ack at n+2.
- Throughput: one word per 4 cycles, one byte per 3 cycles.
- Handshake:
  - A requester deasserts `Req` in the cycle after `Ack`.
  - `Req` still high in the following IDLE cycle is a new transaction.
- Reset mid-transaction:
  - FSM returns to IDLE next cycle; no Ack is issued.
  - A low byte already written stays written. The partial word write is not rolled back.
- Reset dominates simultaneous requests.

## Configuration
- `MEM_ARB_ROUND_ROBIN_EN` defined: round-robin arbitration. On a tie, grant the port not granted last. Update the pointer on every grant.
- Undefined: fixed priority. Port 1 (data) always beats port 0; the pointer logic is not compiled.

## Structure
- Package `mem_arb_pkg`:
  - FSM state enum (IDLE/LO/HI/DONE).
  - Size encodings `SIZE_BYTE`=0, `SIZE_WORD`=1.
  - Port-id constants `PORT_FETCH`=0, `PORT_DATA`=1.
- Sub-module `mem_arb_grant`: combinational grant picker plus the registered last-grant pointer. The top module holds the FSM, latches and memory drive.

## Test plan
- Reset, then P0_Req with Addr=0x0010; memory [0x10]=0x34, [0x11]=0x12 → P0_Ack at cycle 3, P0_RData=0x1234, Mem_CS high outside LO/HI.
- P1 word write Addr=0x0200, WData=0xBEEF, then word read of same address → memory [0x200]=0xEF, [0x201]=0xBE; P1_RData=0xBEEF.
- P1 byte write 0x5A to 0x0300, then byte read → only [0x300] changes; P1_RData=0x005A, Ack at cycle 2.
- P1 word read at 0xFFFF with [0xFFFF]=0xCD, [0x0000]=0xAB → P1_RData=0xABCD (wrap).
- Both ports request continuously for 4 transactions → with macro, grants alternate P0,P1,P0,P1; without macro, all four go to P1.
- Reset asserted during HI of a P1 word write to 0x0400 → no P1_Ack; [0x400] written, [0x401] unchanged; Busy=0 the next cycle.
